// File: rtl/avr_irq_ctrl_pkg.sv
// avr_irq_ctrl_pkg: register offsets and controller state encoding shared by the
// interrupt controller files.
`default_nettype none

package avr_irq_ctrl_pkg;

  localparam logic [1:0] REG_IER = 2'd0;
  localparam logic [1:0] REG_IPR = 2'd1;
  localparam logic [1:0] REG_ITR = 2'd2;
  localparam logic [1:0] REG_ISR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_INSVC = 2'd2
  } irq_state_t;

endpackage

`default_nettype wire

// File: rtl/avr_irq_ctrl_prio.sv
// avr_irq_ctrl_prio: lowest-index priority encoder; index 0 is the highest priority.
`default_nettype none

module avr_irq_ctrl_prio #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 2
) (
  input  logic [N_SRC-1:0] active,
  output logic             any,
  output logic [VEC_W-1:0] sel
);

  always_comb begin
    any = |active;
    sel = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = VEC_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/avr_irq_ctrl.sv
// avr_irq_ctrl: latches, masks and prioritises peripheral interrupt requests for the
// AVR core, with IER/IPR/ITR/ISR software registers and EOI re-arm.
`default_nettype none

module avr_irq_ctrl
  import avr_irq_ctrl_pkg::*;
#(
  parameter int INTR_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         io_re,
  input  logic                         io_we,
  input  logic [1:0]                   io_a,
  input  logic [7:0]                   io_din,
  output logic [7:0]                   io_dout,
  input  logic [(1<<INTR_WIDTH)-1:0]   irq_in,
  output logic                         iflag,
  output logic [INTR_WIDTH-1:0]        ivect,
  input  logic                         irq_ack,
  input  logic [INTR_WIDTH-1:0]        irq_ack_vec
);

  localparam int N_IRQ = 1 << INTR_WIDTH;

  logic [N_IRQ-1:0] ier, itr, ipr, irq_q, ipr_nxt, active;
  logic             any;
  logic [INTR_WIDTH-1:0] sel;
  irq_state_t       state;
  logic [2:0]       svc_vec;
  logic             insvc;

  logic wr_ier, wr_ipr, wr_itr, eoi, ack_take;
  assign wr_ier   = io_we && (io_a == REG_IER);
  assign wr_ipr   = io_we && (io_a == REG_IPR);
  assign wr_itr   = io_we && (io_a == REG_ITR);
  assign eoi      = io_we && (io_a == REG_ISR);
  assign ack_take = irq_ack && (state == ST_REQ);

  logic unused_din;
  assign unused_din = &{1'b0, io_din};

  assign active = ipr & ier;

  avr_irq_ctrl_prio #(
    .N_SRC (N_IRQ),
    .VEC_W (INTR_WIDTH)
  ) u_prio (
    .active (active),
    .any    (any),
    .sel    (sel)
  );

  // Edge bits: a fresh edge wins over a same-cycle W1C or acknowledge.
  always_comb begin
    ipr_nxt = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (itr[i]) begin
        ipr_nxt[i] = (irq_in[i] & ~irq_q[i]) |
                     (ipr[i] & ~(wr_ipr & io_din[i])
                             & ~(ack_take && (irq_ack_vec == INTR_WIDTH'(i))));
      end else begin
        ipr_nxt[i] = irq_in[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ier   <= '0;
      itr   <= '0;
      ipr   <= '0;
      irq_q <= '0;
    end else begin
      irq_q <= irq_in;
      ipr   <= ipr_nxt;
      if (wr_ier) ier <= io_din[N_IRQ-1:0];
      if (wr_itr) itr <= io_din[N_IRQ-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      iflag   <= 1'b0;
      ivect   <= '0;
      svc_vec <= '0;
      insvc   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            state <= ST_REQ;
            iflag <= 1'b1;
            ivect <= sel;
          end
        end
        ST_REQ: begin
          // An acknowledge is honoured even if the request vanished the same cycle.
          if (irq_ack) begin
            state   <= ST_INSVC;
            iflag   <= 1'b0;
            svc_vec <= 3'(irq_ack_vec);
            insvc   <= 1'b1;
          end else if (!any) begin
            state <= ST_IDLE;
            iflag <= 1'b0;
          end else begin
            ivect <= sel;
          end
        end
        ST_INSVC: begin
          if (eoi) begin
            state <= ST_IDLE;
            insvc <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          iflag <= 1'b0;
          insvc <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    io_dout = '0;
    if (io_re) begin
      case (io_a)
        REG_IER: io_dout = 8'(ier);
        REG_IPR: io_dout = 8'(ipr);
        REG_ITR: io_dout = 8'(itr);
        default: io_dout = {insvc, 4'b0000, svc_vec};
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avr_irq_ctrl.sv
// tb_avr_irq_ctrl: directed scenarios plus randomized traffic, checked by a scoreboard
// fed from a cycle-level reference model of the controller rules.
`default_nettype none

module tb_avr_irq_ctrl;

  localparam int W = 2;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         io_re, io_we;
  logic [1:0]   io_a;
  logic [7:0]   io_din, io_dout;
  logic [N-1:0] irq_in;
  logic         iflag;
  logic [W-1:0] ivect;
  logic         irq_ack;
  logic [W-1:0] irq_ack_vec;

  avr_irq_ctrl #(.INTR_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_re       (io_re),
    .io_we       (io_we),
    .io_a        (io_a),
    .io_din      (io_din),
    .io_dout     (io_dout),
    .irq_in      (irq_in),
    .iflag       (iflag),
    .ivect       (ivect),
    .irq_ack     (irq_ack),
    .irq_ack_vec (irq_ack_vec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         iflag;
    logic [W-1:0] ivect;
    logic [7:0]   dout;
  } exp_t;
  exp_t q[$];

  // Reference model: per-source flags plus "requesting" / "in service" booleans.
  bit         m_pen[N], m_en[N], m_trig[N], m_prev[N];
  bit         m_req, m_svc;
  logic [W-1:0] m_vec;
  logic [2:0] m_svcvec;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pen[i] = 0; m_en[i] = 0; m_trig[i] = 0; m_prev[i] = 0;
    end
    m_req = 0; m_svc = 0; m_vec = '0; m_svcvec = '0;
  endfunction

  function automatic logic [7:0] model_read(logic [1:0] a);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (a == 2'd0) v[i] = m_en[i];
      if (a == 2'd1) v[i] = m_pen[i];
      if (a == 2'd2) v[i] = m_trig[i];
    end
    if (a == 2'd3) v = {m_svc, 4'b0000, m_svcvec};
    return v;
  endfunction

  function automatic void model_clock(logic [N-1:0] in, bit we, logic [1:0] a,
                                      logic [7:0] din, bit ack, logic [W-1:0] av);
    int  first;
    bit  was_req;
    first = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pen[i] && m_en[i]) first = i;
    was_req = m_req;
    if (!m_req && !m_svc) begin
      if (first >= 0) begin m_req = 1; m_vec = W'(first); end
    end else if (m_req) begin
      if (ack) begin m_req = 0; m_svc = 1; m_svcvec = 3'(av); end
      else if (first < 0) m_req = 0;
      else m_vec = W'(first);
    end else if (we && a == 2'd3) begin
      m_svc = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_trig[i]) begin
        if (in[i] && !m_prev[i]) m_pen[i] = 1;
        else if ((we && a == 2'd1 && din[i]) || (was_req && ack && av == W'(i))) m_pen[i] = 0;
      end else begin
        m_pen[i] = in[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (we && a == 2'd0) m_en[i] = din[i];
      if (we && a == 2'd2) m_trig[i] = din[i];
      m_prev[i] = in[i];
    end
  endfunction

  function automatic void chk(string name, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endfunction

  // One clock of stimulus; the expectation for the current cycle goes to the scoreboard.
  task automatic step(input logic [N-1:0] in, input bit re = 0, input bit we = 0,
                      input logic [1:0] a = 2'd0, input logic [7:0] din = 8'h00,
                      input bit ack = 0, input logic [W-1:0] av = '0);
    exp_t e;
    irq_in = in; io_re = re; io_we = we; io_a = a; io_din = din;
    irq_ack = ack; irq_ack_vec = av;
    e.iflag = m_req;
    e.ivect = m_vec;
    e.dout  = re ? model_read(a) : 8'h00;
    q.push_back(e);
    @(posedge clk);
    model_clock(in, we, a, din, ack, av);
    #1;
  endtask

  task automatic peek(input logic [1:0] a, input logic [7:0] exp, input string name);
    io_re = 1; io_we = 0; io_a = a; irq_ack = 0;
    #1;
    chk(name, io_dout, exp);
  endtask

  task automatic do_reset(input logic [N-1:0] in);
    rst = 1; irq_in = in; io_re = 0; io_we = 0; irq_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (iflag !== e.iflag) begin
        bad++;
        $display("FAIL sb_iflag @%0t: got=%b expected=%b", $time, iflag, e.iflag);
      end
      if (e.iflag) begin
        total++;
        if (ivect !== e.ivect) begin
          bad++;
          $display("FAIL sb_ivect @%0t: got=%0d expected=%0d", $time, ivect, e.ivect);
        end
      end
      total++;
      if (io_dout !== e.dout) begin
        bad++;
        $display("FAIL sb_dout @%0t: got=%h expected=%h", $time, io_dout, e.dout);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rin;
    logic [W-1:0] rav;
    rst = 1; io_re = 0; io_we = 0; io_a = '0; io_din = '0;
    irq_in = '0; irq_ack = 0; irq_ack_vec = '0;
    do_reset('0);
    chk("reset_iflag", 8'(iflag), 8'h00);
    chk("reset_ivect", 8'(ivect), 8'h00);
    for (int r = 0; r < 4; r++) step('0, 1, 0, 2'(r));

    // 1: single edge pulse on source 0
    step('0, 0, 1, 2'd0, 8'h01);
    step('0, 0, 1, 2'd2, 8'h01);
    step(4'h1);
    peek(2'd1, 8'h01, "t1_ipr");
    chk("t1_iflag_early", 8'(iflag), 8'h00);
    step(4'h0);
    chk("t1_iflag", 8'(iflag), 8'h01);
    chk("t1_ivect", 8'(ivect), 8'h00);
    step('0, 0, 0, 2'd0, 8'h00, 1, 2'd0);
    peek(2'd3, 8'h80, "t1_isr");
    step('0, 0, 1, 2'd3, 8'h00);

    // 2: simultaneous edges on sources 3 and 1
    do_reset('0);
    step('0, 0, 1, 2'd0, 8'h0F);
    step('0, 0, 1, 2'd2, 8'h0F);
    step(4'hA);
    step(4'h0);
    chk("t2_ivect1", 8'(ivect), 8'h01);
    step('0, 0, 0, 2'd0, 8'h00, 1, 2'd1);
    chk("t2_iflag_svc", 8'(iflag), 8'h00);
    peek(2'd1, 8'h08, "t2_ipr");
    peek(2'd3, 8'h81, "t2_isr");
    step('0, 0, 1, 2'd3, 8'h00);
    step('0);
    chk("t2_iflag_eoi", 8'(iflag), 8'h01);
    chk("t2_ivect3", 8'(ivect), 8'h03);

    // 3: level source 2, W1C has no effect
    do_reset('0);
    step('0, 0, 1, 2'd0, 8'h04);
    step(4'h4);
    step(4'h4);
    chk("t3_iflag", 8'(iflag), 8'h01);
    step(4'h4, 0, 1, 2'd1, 8'h04);
    peek(2'd1, 8'h04, "t3_ipr_w1c");
    step(4'h0);
    step(4'h0);
    chk("t3_iflag_drop", 8'(iflag), 8'h00);
    peek(2'd1, 8'h00, "t3_ipr_clr");

    // 4: masking a pending request
    do_reset('0);
    step('0, 0, 1, 2'd0, 8'h01);
    step('0, 0, 1, 2'd2, 8'h01);
    step(4'h1);
    step(4'h0);
    step('0, 0, 1, 2'd0, 8'h00);
    step('0);
    chk("t4_masked", 8'(iflag), 8'h00);
    step('0, 0, 1, 2'd0, 8'h01);
    step('0);
    chk("t4_reenabled", 8'(iflag), 8'h01);

    // 5: new edge on the bit being acknowledged
    do_reset('0);
    step('0, 0, 1, 2'd0, 8'h02);
    step('0, 0, 1, 2'd2, 8'h02);
    step(4'h2);
    step(4'h0);
    step(4'h2, 0, 0, 2'd0, 8'h00, 1, 2'd1);
    chk("t5_iflag_svc", 8'(iflag), 8'h00);
    peek(2'd1, 8'h02, "t5_ipr_kept");
    step(4'h2, 0, 1, 2'd3, 8'h00);
    step(4'h2);
    chk("t5_iflag", 8'(iflag), 8'h01);
    chk("t5_ivect", 8'(ivect), 8'h01);

    // 6: reset while in service with source 1 held high
    step(4'h2, 0, 0, 2'd0, 8'h00, 1, 2'd1);
    rst = 1; io_re = 1; io_a = 2'd3; io_we = 0; irq_ack = 0;
    model_reset();
    #1;
    chk("t6_rst_iflag", 8'(iflag), 8'h00);
    chk("t6_rst_isr", io_dout, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    peek(2'd1, 8'h00, "t6_ipr_after");
    step(4'h2, 0, 1, 2'd2, 8'h02);
    step(4'h2, 0, 1, 2'd1, 8'h02);
    step(4'h2, 0, 1, 2'd0, 8'h02);
    step(4'h2);
    step(4'h2);
    chk("t6_no_iflag", 8'(iflag), 8'h00);
    step(4'h0);
    step(4'h2);
    step(4'h2);
    chk("t6_edge_iflag", 8'(iflag), 8'h01);

    // Randomized traffic
    do_reset('0);
    for (int c = 0; c < 600; c++) begin
      rin = N'($urandom);
      if (m_req && $urandom_range(0, 2) == 0) begin
        rav = ($urandom_range(0, 3) == 0) ? W'($urandom) : m_vec;
        step(rin, 1'($urandom), 0, 2'($urandom), 8'h00, 1, rav);
      end else if ($urandom_range(0, 3) == 0) begin
        step(rin, 1'($urandom), 1, 2'($urandom), 8'($urandom));
      end else begin
        step(rin, 1'($urandom), 0, 2'($urandom));
      end
    end

    step('0);
    @(posedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got=%0d entries left expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
